sudoku_cell_streamer: RTL and testbench
=======================================

Name: sudoku_cell_streamer

Overview:
- Buffers the 81 recognised cells produced by the handwritten-digit classifier.
- Classifier results may arrive in any order, each tagged with a cell index.
- Once the board is complete, replays the cells in raster order into the sudoku validity checker.
- Uses the checker's start/data serial protocol, waits for its done/valid, and reports one verdict per board.

Parameters:
- N_CELLS, 81, number of board cells; fixed 9x9.
- IDX_W, 7, cell index width.
- DIGIT_W, 4, classifier digit width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  classifier cell result present.
- in_ready  out  1  streamer accepting cell writes.
- in_index  in  IDX_W  cell index, row*9+col, 0..80.
- in_empty  in  1  cell recognised as blank.
- in_digit  in  DIGIT_W  recognised digit 1..9; ignored when in_empty=1.
- go  in  1  request to check the buffered board; 1-cycle pulse.
- chk_start  out  1  checker start/strobe; one cell per high cycle.
- chk_data  out  11  checker cell word. Bit 10 = empty; bits 9:0 = one-hot digit (bit d set for digit d).
- chk_done  in  1  checker done.
- chk_valid  in  1  checker board-valid.
- busy  out  1  high from go acceptance until result_valid.
- result_valid  out  1  1-cycle pulse when the verdict is available.
- result_ok  out  1  latched chk_valid; held until the next accepted go.
- fmt_err  out  1  sticky error for a bad write; cleared by reset or an accepted go.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: in_ready=1, chk_start=0, chk_data=11'h400, busy=0, result_valid=0, result_ok=0, fmt_err=0.
- Reset also clears the 81-bit filled bitmap and the fill count, and puts the FSM in LOAD. Reset mid-operation aborts immediately; the checker shares the same reset.
- Storage: 81 x 11-bit cell words plus the filled bitmap. All outputs are registered.
- Encoding on write: in_empty=1 -> 11'h400. Otherwise digit d (1..9) -> {1'b0, 10'b1<<d}.
- Write rules, LOAD only, when in_valid & in_ready:
  - in_index>=81 -> write dropped, fmt_err set.
  - in_digit of 0 or >9 with in_empty=0 -> cell stored as 11'h400, marked filled, fmt_err set.
  - Rewrite of an already-filled cell -> overwrites; fill count unchanged.
- FSM states: LOAD, KICK, STREAM, WAIT, REPORT.
- LOAD:
  - in_ready=1.
  - go accepted only if fill count==81 before the current cycle's write; otherwise go is ignored.
  - A write and a go in the same cycle: the write is performed, and go is judged on the pre-write count.
  - On acceptance: busy=1, in_ready=0, result_ok=0, fmt_err=0. Next state is KICK if chk_done=1 that cycle, else STREAM.
- KICK: the checker is sitting in Finish. Drive chk_start=1 for one cycle with chk_data=11'h400; the checker consumes no cell. -> STREAM.
- STREAM:
  - chk_start=1 for exactly 81 consecutive cycles.
  - chk_data = cell[k] for k=0..80, aligned in the same cycle as chk_start.
  - After k=80 -> WAIT, with chk_start=0 and chk_data=11'h400.
- WAIT:
  - When chk_done=1: capture result_ok<=chk_valid, -> REPORT.
  - No timeout; only reset escapes.
- REPORT:
  - result_valid=1 for one cycle; busy=0; filled bitmap and count cleared; in_ready=1 next cycle; -> LOAD.
  - result_ok holds its value.
- Latency without KICK: go accepted at cycle T; chk_start high T+1..T+81; chk_done seen at T+82; result_valid at T+83. KICK adds 1 cycle.
- go while busy is ignored. in_valid outside LOAD is ignored (in_ready=0).

Optional Feature:
- Macro: SUDOKU_PARTIAL_GO_EN.
- Defined: go is accepted at any fill count. Unfilled cells stream as 11'h400 (empty), so partial boards can be checked.
- Undefined: go is ignored until all 81 cells are filled, as specified above.

Test Plan:
- Write a valid solved board in reverse index order, then go; chk_done rises after the 81st start -> chk_data sequence matches raster order, result_valid at T+83, result_ok=1.
- Same board with cell 0 rewritten to duplicate cell 1's digit, then go -> result_ok=0; fill count stays 81; go accepted.
- 80 cells written, then go -> no chk_start, busy=0. With SUDOKU_PARTIAL_GO_EN: the missing cell streams as 11'h400, and a valid partial board gives result_ok=1.
- Write index 81, and write digit 0 with in_empty=0 at index 5 -> fmt_err=1, cell 5 = 11'h400. fmt_err clears on the next accepted go.
- Second board after a first verdict (checker done=1) -> one KICK cycle with chk_start=1, then 81 data cycles; result_valid at T+84.
- Reset asserted at stream cycle 40 -> next cycle all outputs at reset values, in LOAD, fill count 0.

Source files
------------

// File: rtl/sudoku_cell_streamer.sv
// sudoku_cell_streamer
//   Collects the 81 classifier results (any order, tagged by cell index),
//   then replays them in raster order into the sudoku validity checker using
//   its start/data serial protocol, and reports one verdict per board.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   in_valid/in_ready  cell write handshake (accepted only in LOAD)
//   in_index           cell index row*9+col, 0..80
//   in_empty/in_digit  blank flag / digit 1..9
//   go                 1-cycle request to check the buffered board
//   chk_start/chk_data checker strobe and cell word {empty, onehot[9:0]}
//   chk_done/chk_valid checker completion and board verdict
//   busy               high from go acceptance until result_valid
//   result_valid       1-cycle verdict pulse; result_ok holds the verdict
//   fmt_err            sticky bad-write flag, cleared by reset or accepted go
//
// Build option
//   SUDOKU_PARTIAL_GO_EN : accept go at any fill count; unfilled cells
//                          stream as empty.
module sudoku_cell_streamer #(
  parameter int N_CELLS = 81,
  parameter int IDX_W   = 7,
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   in_index,
  input  logic               in_empty,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               go,
  output logic               chk_start,
  output logic [10:0]        chk_data,
  input  logic               chk_done,
  input  logic               chk_valid,
  output logic               busy,
  output logic               result_valid,
  output logic               result_ok,
  output logic               fmt_err
);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_KICK   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  localparam logic [10:0] EMPTY_W = 11'h400;

  logic [2:0]         state_q, state_d;
  logic [10:0]        cell_q [N_CELLS];
  logic [N_CELLS-1:0] filled_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   k_q;       // next cell to stream
  logic               in_ready_q, chk_start_q, busy_q, rv_q, ok_q, fmt_q;
  logic [10:0]        chk_data_q;

  logic        wr_en, idx_ok, dig_ok, wr_bad, go_ok, go_acc, wr_hit_k;
  logic [10:0] wr_word, rd_word;

  assign wr_en   = (state_q == S_LOAD) && in_valid && in_ready_q;
  assign idx_ok  = in_index < IDX_W'(N_CELLS);
  assign dig_ok  = (in_digit >= DIGIT_W'(1)) && (in_digit <= DIGIT_W'(9));
  assign wr_word = (in_empty || !dig_ok) ? EMPTY_W : (11'd1 << in_digit);
  assign wr_bad  = wr_en && (!idx_ok || (!in_empty && !dig_ok));

`ifdef SUDOKU_PARTIAL_GO_EN
  assign go_ok = 1'b1;
`else
  // Judged on the count before any write landing in the same cycle.
  assign go_ok = (cnt_q == IDX_W'(N_CELLS));
`endif
  assign go_acc = (state_q == S_LOAD) && go && go_ok;

  // A write to cell 0 in the go cycle must be the value streamed first.
  assign wr_hit_k = wr_en && idx_ok && (in_index == k_q);
  assign rd_word  = wr_hit_k       ? wr_word   :
                    filled_q[k_q]  ? cell_q[k_q] : EMPTY_W;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (go_acc) state_d = chk_done ? S_KICK : S_STREAM;
      S_KICK:   state_d = S_STREAM;
      S_STREAM: if (k_q == IDX_W'(N_CELLS)) state_d = S_WAIT;
      S_WAIT:   if (chk_done) state_d = S_REPORT;
      S_REPORT: state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  // Cell storage needs no reset: the filled bitmap qualifies every read.
  always_ff @(posedge clk) begin
    if (wr_en && idx_ok) cell_q[in_index] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      filled_q    <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      chk_start_q <= 1'b0;
      chk_data_q  <= EMPTY_W;
      busy_q      <= 1'b0;
      rv_q        <= 1'b0;
      ok_q        <= 1'b0;
      fmt_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (go_acc)      fmt_q <= 1'b0;
      else if (wr_bad) fmt_q <= 1'b1;
      case (state_q)
        S_LOAD: begin
          if (wr_en && idx_ok) begin
            filled_q[in_index] <= 1'b1;
            if (!filled_q[in_index]) cnt_q <= cnt_q + 1'b1;
          end
          if (go_acc) begin
            busy_q      <= 1'b1;
            in_ready_q  <= 1'b0;
            ok_q        <= 1'b0;
            chk_start_q <= 1'b1;
            if (chk_done) begin
              // Checker parked in Finish: this strobe only restarts it.
              chk_data_q <= EMPTY_W;
            end else begin
              chk_data_q <= rd_word;
              k_q        <= k_q + 1'b1;
            end
          end
        end
        S_KICK: begin
          chk_data_q <= rd_word;
          k_q        <= k_q + 1'b1;
        end
        S_STREAM: begin
          if (k_q == IDX_W'(N_CELLS)) begin
            chk_start_q <= 1'b0;
            chk_data_q  <= EMPTY_W;
          end else begin
            chk_data_q <= rd_word;
            k_q        <= k_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (chk_done) begin
            ok_q   <= chk_valid;
            rv_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        S_REPORT: begin
          rv_q       <= 1'b0;
          in_ready_q <= 1'b1;
          filled_q   <= '0;
          cnt_q      <= '0;
          k_q        <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign chk_start    = chk_start_q;
  assign chk_data     = chk_data_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result_ok    = ok_q;
  assign fmt_err      = fmt_q;

endmodule

// File: tb/tb_sudoku_cell_streamer.sv
// Bench for sudoku_cell_streamer: a behavioural checker model drives
// chk_done/chk_valid; expected cell words are queued at go and popped as
// chk_start strobes appear.
module tb_sudoku_cell_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_empty, go;
  logic [6:0]  in_index;
  logic [3:0]  in_digit;
  logic        chk_start, chk_done, chk_valid;
  logic [10:0] chk_data;
  logic        busy, result_valid, result_ok, fmt_err;

  int n_vec = 0;
  int n_err = 0;

  logic [10:0] tb_cell [81];
  logic [80:0] tb_filled;
  logic [10:0] exp_q [$];

  sudoku_cell_streamer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index),
    .in_empty(in_empty), .in_digit(in_digit), .go(go),
    .chk_start(chk_start), .chk_data(chk_data),
    .chk_done(chk_done), .chk_valid(chk_valid),
    .busy(busy), .result_valid(result_valid), .result_ok(result_ok),
    .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  // ---------------- checker model ----------------
  logic [10:0] cm_cells [81];
  int          cm_cnt;
  logic        cm_done, cm_valid;
  assign chk_done  = cm_done;
  assign chk_valid = cm_valid;

  // No duplicate digit in any row/col/box; blanks allowed.
  function automatic logic board_ok(input logic [10:0] last);
    logic ok = 1'b1;
    for (int g = 0; g < 27; g++) begin
      logic [9:0] seen = '0;
      for (int j = 0; j < 9; j++) begin
        int idx;
        logic [10:0] w;
        if (g < 9)       idx = g * 9 + j;
        else if (g < 18) idx = j * 9 + (g - 9);
        else             idx = (((g - 18) / 3) * 3 + j / 3) * 9 + ((g - 18) % 3) * 3 + j % 3;
        w = (idx == 80) ? last : cm_cells[idx];
        if (!w[10]) begin
          if ($countones(w[9:0]) != 1 || w[0]) ok = 1'b0;
          if ((seen & w[9:0]) != 0) ok = 1'b0;
          seen = seen | w[9:0];
        end
      end
    end
    return ok;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cm_done <= 1'b0; cm_valid <= 1'b0; cm_cnt <= 0;
    end else if (chk_start) begin
      if (cm_done) begin
        cm_done <= 1'b0; cm_cnt <= 0;
      end else if (cm_cnt < 81) begin
        cm_cells[cm_cnt] <= chk_data;
        cm_cnt <= cm_cnt + 1;
        if (cm_cnt == 80) begin
          cm_done  <= 1'b1;
          cm_valid <= board_ok(chk_data);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic int sol(input int k);
    int r = k / 9;
    int c = k % 9;
    return ((r * 3 + r / 3 + c) % 9) + 1;
  endfunction

  function automatic logic [10:0] enc(input bit emp, input int d);
    if (emp || d < 1 || d > 9) return 11'h400;
    return 11'd1 << d;
  endfunction

  task automatic wr(input int idx, input bit emp, input int dig);
    in_valid = 1'b1; in_index = 7'(idx); in_empty = emp; in_digit = 4'(dig);
    @(negedge clk);
    in_valid = 1'b0;
    if (idx < 81) begin
      tb_filled[idx] = 1'b1;
      tb_cell[idx]   = enc(emp, dig);
    end
  endtask

  task automatic write_board(input int skip);
    for (int k = 80; k >= 0; k--) if (k != skip) wr(k, 1'b0, sol(k));
  endtask

  task automatic push_expected();
    exp_q.delete();
    for (int k = 0; k < 81; k++) exp_q.push_back(tb_filled[k] ? tb_cell[k] : 11'h400);
  endtask

  // Pulses go and follows the whole exchange cycle by cycle (T+i).
  task automatic run_board(input bit kick, input bit exp_ok);
    int lat  = kick ? 84 : 83;
    int last = kick ? 82 : 81;
    int rv_cnt = 0;
    logic [10:0] w;
    go = 1'b1; @(negedge clk); go = 1'b0;
    for (int i = 1; i <= lat + 2; i++) begin
      n_vec++;
      if (chk_start !== (i <= last)) begin
        n_err++; $display("FAIL chk_start T+%0d: got %b want %b", i, chk_start, i <= last);
      end
      if (chk_start && i <= last) begin
        if (kick && i == 1)        w = 11'h400;
        else if (exp_q.size() > 0) w = exp_q.pop_front();
        else                       w = 11'h7ff;
        n_vec++;
        if (chk_data !== w) begin
          n_err++; $display("FAIL chk_data T+%0d: got %h want %h", i, chk_data, w);
        end
      end
      if (i == 1) begin
        n_vec++;
        if ({busy, in_ready, fmt_err, result_ok} !== 4'b1000) begin
          n_err++; $display("FAIL accept {busy,rdy,fmt,ok}: got %b want 1000", {busy, in_ready, fmt_err, result_ok});
        end
      end
      n_vec++;
      if (result_valid !== (i == lat)) begin
        n_err++; $display("FAIL result_valid T+%0d: got %b want %b", i, result_valid, i == lat);
      end
      if (result_valid) rv_cnt++;
      if (i == lat) begin
        n_vec++;
        if (result_ok !== exp_ok || busy !== 1'b0) begin
          n_err++; $display("FAIL verdict {ok,busy}: got %b%b want %b0", result_ok, busy, exp_ok);
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (rv_cnt != 1 || exp_q.size() != 0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL board end: rv_pulses %0d left %0d in_ready %b, want 1 0 1", rv_cnt, exp_q.size(), in_ready);
    end
    tb_filled = '0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      n_vec++;
      if (chk_start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        n_err++; $display("FAIL %s idle %0d: start %b busy %b rdy %b, want 0 0 1", name, i, chk_start, busy, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_vec++;
    if ({in_ready, chk_start, chk_data, busy, result_valid, result_ok, fmt_err} !== {1'b1, 1'b0, 11'h400, 4'b0000}) begin
      n_err++;
      $display("FAIL %s: rdy %b start %b data %h busy %b rv %b ok %b fmt %b, want 1 0 400 0 0 0 0",
               name, in_ready, chk_start, chk_data, busy, result_valid, result_ok, fmt_err);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tb_filled = '0;
    check_reset_vals("reset");
  endtask

  task automatic test_full_board();
    write_board(-1);
    push_expected();
    run_board(1'b0, 1'b1);
  endtask

  task automatic test_dup();
    write_board(-1);
    wr(0, 1'b0, sol(1));  // rewrite: count must stay 81 or go would be ignored
    push_expected();
    run_board(1'b1, 1'b0);
  endtask

  task automatic test_partial();
    write_board(5);
`ifdef SUDOKU_PARTIAL_GO_EN
    push_expected();
    run_board(1'b1, 1'b1);
`else
    go = 1'b1; @(negedge clk); go = 1'b0;
    check_idle("partial", 20);
    n_vec++;
    if (fmt_err !== 1'b0) begin
      n_err++; $display("FAIL partial fmt_err: got %b want 0", fmt_err);
    end
`endif
  endtask

  task automatic test_fmt_err();
    wr(81, 1'b0, 3);
    n_vec++;
    if (fmt_err !== 1'b1) begin
      n_err++; $display("FAIL fmt idx81: got %b want 1", fmt_err);
    end
    write_board(5);
    wr(5, 1'b0, 0);
    n_vec++;
    if (fmt_err !== 1'b1) begin
      n_err++; $display("FAIL fmt digit0: got %b want 1", fmt_err);
    end
    push_expected();
    run_board(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    write_board(-1);
    push_expected();
    go = 1'b1; @(negedge clk); go = 1'b0;
    repeat (39) @(negedge clk);
    n_vec++;
    if (chk_start !== 1'b1) begin
      n_err++; $display("FAIL midstream start: got %b want 1", chk_start);
    end
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid reset");
    reset = 1'b0;
    tb_filled = '0;
    exp_q.delete();
    @(negedge clk);
`ifdef SUDOKU_PARTIAL_GO_EN
    push_expected();  // all cells empty after reset
    run_board(1'b0, 1'b1);
`else
    go = 1'b1; @(negedge clk); go = 1'b0;
    check_idle("post reset", 20);
`endif
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_index = '0; in_empty = 1'b0;
    in_digit = '0; go = 1'b0; tb_filled = '0;
    @(negedge clk);
    test_reset();
    test_full_board();
    test_dup();
    test_partial();
    test_fmt_err();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
